// File: rtl/bitwise_op_sched.sv
// -----------------------------------------------------------------------------
// bitwise_op_sched
//
// Sequencing controller for the 4-bit bitwise operator set. One command
// (operands x, y, z plus a 6-bit op-select mask) is accepted over a
// valid/ready handshake. The selected ops are then evaluated one per cycle,
// in ascending index order, through a single shared evaluator. Each result
// is streamed out, tagged with its op index, over a second valid/ready
// handshake.
//
// Op encoding (bitwise, WIDTH bits):
//   op0 = x & y      op1 = x | y      op2 = x ^ y
//   op3 = ~x         op4 = ~(x | y)   op5 = (x & y) | z
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   command present
//   in_ready   out  block can accept a command (IDLE only)
//   in_x/y/z   in   operands, WIDTH bits
//   in_mask    in   op-select mask, bit k enables op k
//   out_valid  out  result present (RUN only)
//   out_ready  in   consumer accepts result
//   out_data   out  result value
//   out_op     out  index of the op producing out_data
//   out_last   out  out_data is the final result of the command
//   done       out  one-cycle pulse when the command is fully retired
//   busy       out  command in progress (RUN or DONE)
// -----------------------------------------------------------------------------
module bitwise_op_sched #(
    parameter int WIDTH = 4,
    parameter int NOPS  = 6     // fixed: the op set has exactly six members
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_z,
    input  logic [NOPS-1:0]  in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_op,
    output logic             out_last,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Shared bitwise evaluator
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] f_eval(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] z
    );
        logic [WIDTH-1:0] res;
        res = '0;
        case (op)
            3'd0:    res = x & y;
            3'd1:    res = x | y;
            3'd2:    res = x ^ y;
            3'd3:    res = ~x;
            3'd4:    res = ~(x | y);
            3'd5:    res = (x & y) | z;
            default: res = '0;
        endcase
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_z;
    logic [NOPS-1:0]  r_rem;        // ops still to be emitted

    logic             w_run;
    logic             w_accept;
    logic             w_fire;
    logic [2:0]       w_op_idx;
    logic [NOPS-1:0]  w_rem_drop;   // r_rem with its lowest set bit cleared
    logic             w_rem_one;

    assign w_run    = (r_state == ST_RUN);
    assign w_accept = in_valid && in_ready;
    assign w_fire   = out_valid && out_ready;

    // x & (x-1) clears the lowest set bit; if that leaves nothing, exactly
    // one bit was set, so the op being presented is the last one.
    assign w_rem_drop = r_rem & (r_rem - 1'b1);
    assign w_rem_one  = (r_rem != '0) && (w_rem_drop == '0);

    // Lowest set bit wins: scan from the top so the last hit is the lowest.
    // NOTE: every always_comb output gets a default first, otherwise a path
    // that assigns nothing would infer a latch.
    always_comb begin
        w_op_idx = '0;
        for (int k = NOPS - 1; k >= 0; k--) begin
            if (r_rem[k]) begin
                w_op_idx = 3'(k);
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (in_mask != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (w_fire && w_rem_one) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Operand latch and pending-op mask
    // -------------------------------------------------------------------------
    // Operands only load in IDLE, so traffic on the input side while a
    // command is in flight cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x   <= '0;
            r_y   <= '0;
            r_z   <= '0;
            r_rem <= '0;
        end else begin
            if (w_accept) begin
                r_x   <= in_x;
                r_y   <= in_y;
                r_z   <= in_z;
                r_rem <= in_mask;
            end else if (w_run && w_fire) begin
                r_rem <= w_rem_drop;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: combinational from registers only, so they are glitch-free
    // relative to the handshake and hold steady while the consumer stalls.
    // Result fields are forced to zero outside RUN.
    // -------------------------------------------------------------------------
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = w_run;
    assign out_op    = w_run ? w_op_idx : 3'd0;
    assign out_data  = w_run ? f_eval(w_op_idx, r_x, r_y, r_z) : '0;
    assign out_last  = w_run && w_rem_one;
    assign done      = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);

endmodule
